dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter that shares the single data-memory port between the pipeline load/store stage (port 0) and the debug/DMA loader (port 1). It chooses one requester per cycle with round-robin tie-break and a bounded burst counter. It drives the memory's write-enable, address and write data, and routes the one-cycle-late read data back to the port that issued the read.

## Interface
- DATA_BIT_WIDTH, 32, width of addresses and data on every port
- BURST_MAX, 4, maximum consecutive grants to one port while the other port is requesting; legal range 1..15
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  port requests an access this cycle
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  DATA_BIT_WIDTH  byte address
- wdata0 / wdata1  in  DATA_BIT_WIDTH  write data
- gnt0 / gnt1  out  1  combinational grant; an access is accepted on a posedge where req & gnt
- rdata0 / rdata1  out  DATA_BIT_WIDTH  both carry mem_rdata; meaningful only with the matching rvalid
- rvalid0 / rvalid1  out  1  registered; read data for that port is valid this cycle
- mem_we  out  1  write enable to data memory
- mem_addr  out  DATA_BIT_WIDTH  address to data memory
- mem_wdata  out  DATA_BIT_WIDTH  write data to data memory
- mem_rdata  in  DATA_BIT_WIDTH  memory read data, valid one cycle after the address is presented

## Operation
- State registers:
  - owner: IDLE, OWN0 or OWN1; names the port granted last cycle.
  - cnt: consecutive grants to owner; 4 bits, saturates at BURST_MAX.
  - last: the most recently served port.
  - rsel: port whose read is in flight.
  - rpend: a read is in flight.
- Grant decision is combinational from the registered state and req0/req1. At most one gnt is high.
  - Owner OWNx, reqx = 1, and (other port idle or cnt < BURST_MAX): grant x. On the clock, cnt = min(cnt+1, BURST_MAX).
  - Otherwise, if the other port y requests: grant y. On the clock, owner = OWNy and cnt = 1.
  - Otherwise, with owner IDLE or the owner's req dropped: if both request, grant the port that is not `last`; if one requests, grant it. cnt = 1.
  - No request: no grant. On the clock, owner = IDLE and cnt = 0. `last` is retained.
- `last` updates to the granted port on every grant.
- While a port is granted, mem_we = req & we, mem_addr = addr and mem_wdata = wdata of that port.
- With no grant, mem_we = 0, mem_addr = 0 and mem_wdata = 0.
- An accepted read (we = 0) sets rpend = 1 and rsel = port on the clock. The next cycle asserts rvalid[rsel].
- rpend clears on the clock after a cycle with no accepted read.
- Back-to-back reads produce back-to-back rvalid, alternating ports if the grants alternated.
- Writes never produce rvalid.
- A request held with gnt low is stalled. The requester keeps req, we, addr and wdata stable until granted; the arbiter does not latch them.

## Timing
- Reset values:
  - owner = IDLE, cnt = 0, last = 1 (so port 0 wins the first tie), rpend = 0.
  - All rvalid = 0; the mem_* outputs follow the combinational rules above.
- Grant latency is 0 cycles: gnt is high in the same cycle as req when the port is chosen.
- Read data latency is 1 cycle after acceptance.
- Write lands in memory on the clock of acceptance.
- Burst boundary: when both ports request continuously, the pattern is BURST_MAX grants to one port, then BURST_MAX to the other, and so on.
- With BURST_MAX = 1 the grants alternate every cycle.
- A single requester is never throttled; cnt saturates and it keeps the grant indefinitely.
- Reset asserted while a read is in flight: rvalid is 0 the following cycle and the read is dropped.
- Reset has priority over all requests in that cycle's state update.
- A read and a write from different ports in consecutive cycles to the same address: the read returns memory content as of its acceptance clock, with no forwarding.

## Structure
- Shared package dmem_arb_pkg:
  - owner state encodings OWN_IDLE = 2'd0, OWN_P0 = 2'd1, OWN_P1 = 2'd2;
  - port index constants PORT_CORE = 1'b0, PORT_DBG = 1'b1.
- Sub-module rr_pick2 (combinational): inputs req[1:0], owner, cnt, last; output grant[1:0]. It holds the full decision logic and is unit-testable on its own.
- The top level holds the registers, the mem_* mux and the rvalid pipeline.

## Test plan
- Reset, then req0 = 1 write addr 0x10 data 0xA5 -> gnt0 = 1 in the same cycle, mem_we = 1, mem_addr = 0x10, mem_wdata = 0xA5, rvalid0 = 0.
- Both request reads from reset with BURST_MAX = 4, held 12 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0,0,0. Each rvalid follows its grant by 1 cycle with mem_rdata routed to the matching port.
- Only req1 held 20 cycles -> gnt1 = 1 every cycle, cnt saturates at 4, no gap.
- From IDLE with last = 0, req0 and req1 rise together -> gnt1 = 1 first. The next tie after both drop goes to port 0.
- Port 0 read accepted, reset asserted the next cycle -> rvalid0 = 0, owner = IDLE, and the following tie is granted to port 0.
- BURST_MAX = 1, port 0 writes 0x55 to addr 0x20 while port 1 reads 0x20 continuously -> grants alternate. Port 1's first rvalid returns the old value and the next returns 0x55.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-port grant decision: sticky owner bounded by a burst limit, round-robin on ties.
module rr_pick2
  import dmem_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic [1:0]       req,
  input  owner_e           owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             last,
  output logic [1:0]       grant
);

  logic under_limit;

  assign under_limit = cnt < CNT_W'(BURST_MAX);

  always_comb begin
    grant = 2'b00;
    case (owner)
      OWN_P0: begin
        if (req[0] && (!req[1] || under_limit)) grant = 2'b01;
        else if (req[1])                        grant = 2'b10;
      end
      OWN_P1: begin
        if (req[1] && (!req[0] || under_limit)) grant = 2'b10;
        else if (req[0])                        grant = 2'b01;
      end
      default: begin
        // On a tie, the port that was not served last wins.
        if (req == 2'b11) grant = (last == PORT_DBG) ? 2'b01 : 2'b10;
        else              grant = req;
      end
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core LSU (port 0) and the debug/DMA loader (port 1).
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH = 32,
  parameter int unsigned BURST_MAX      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [DATA_BIT_WIDTH-1:0] addr0,
  input  logic [DATA_BIT_WIDTH-1:0] addr1,
  input  logic [DATA_BIT_WIDTH-1:0] wdata0,
  input  logic [DATA_BIT_WIDTH-1:0] wdata1,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic [DATA_BIT_WIDTH-1:0] rdata0,
  output logic [DATA_BIT_WIDTH-1:0] rdata1,
  output logic                      rvalid0,
  output logic                      rvalid1,
  output logic                      mem_we,
  output logic [DATA_BIT_WIDTH-1:0] mem_addr,
  output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
  input  logic [DATA_BIT_WIDTH-1:0] mem_rdata
);

  owner_e           owner;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             rsel;
  logic             rpend;

  logic [1:0] grant;
  logic       any_gnt;
  logic       gnt_port;
  logic       acc_read;
  logic       stay;

  rr_pick2 #(.BURST_MAX(BURST_MAX)) u_pick (
    .req   ({req1, req0}),
    .owner (owner),
    .cnt   (cnt),
    .last  (last),
    .grant (grant)
  );

  assign gnt0     = grant[0];
  assign gnt1     = grant[1];
  assign any_gnt  = |grant;
  assign gnt_port = grant[1];
  assign acc_read = any_gnt && !(grant[1] ? we1 : we0);
  assign stay     = (grant[0] && owner == OWN_P0) || (grant[1] && owner == OWN_P1);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[0]) begin
      mem_we    = req0 & we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (grant[1]) begin
      mem_we    = req1 & we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= OWN_IDLE;
      cnt   <= '0;
      last  <= PORT_DBG;
      rsel  <= PORT_CORE;
      rpend <= 1'b0;
    end else begin
      if (!any_gnt) begin
        owner <= OWN_IDLE;
        cnt   <= '0;
      end else if (stay) begin
        if (cnt >= CNT_W'(BURST_MAX)) cnt <= CNT_W'(BURST_MAX);
        else                          cnt <= cnt + CNT_W'(1);
      end else begin
        owner <= gnt_port ? OWN_P1 : OWN_P0;
        cnt   <= CNT_W'(1);
      end
      if (any_gnt) last <= gnt_port;
      rpend <= acc_read;
      if (acc_read) rsel <= gnt_port;
    end
  end

  // Read data is shared; rvalid steers it to the port whose read is in flight.
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
  assign rvalid0 = rpend && (rsel == PORT_CORE);
  assign rvalid1 = rpend && (rsel == PORT_DBG);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: BURST_MAX=4 and BURST_MAX=1 instances share stimulus.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  logic req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic cur;

  logic a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_we;
  logic [31:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] a_mem [0:255];
  logic [31:0] b_mem [0:255];
  logic [31:0] sh    [0:255];
  logic [32:0] q [$];

  int total = 0;
  int bad   = 0;

  dmem_port_arbiter #(.DATA_BIT_WIDTH(32), .BURST_MAX(4)) dut4 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rdata0(a_rdata0), .rdata1(a_rdata1),
    .rvalid0(a_rvalid0), .rvalid1(a_rvalid1), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_port_arbiter #(.DATA_BIT_WIDTH(32), .BURST_MAX(1)) dut1 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: data for an address appears the cycle after it is presented.
  always @(posedge clk) begin
    if (a_mem_we) a_mem[a_mem_addr[7:0]] <= a_mem_wdata;
    a_mem_rdata <= a_mem[a_mem_addr[7:0]];
    if (b_mem_we) b_mem[b_mem_addr[7:0]] <= b_mem_wdata;
    b_mem_rdata <= b_mem[b_mem_addr[7:0]];
  end

  wire        s_gnt0   = cur ? b_gnt0   : a_gnt0;
  wire        s_gnt1   = cur ? b_gnt1   : a_gnt1;
  wire        s_rv0    = cur ? b_rvalid0 : a_rvalid0;
  wire        s_rv1    = cur ? b_rvalid1 : a_rvalid1;
  wire [31:0] s_rd0    = cur ? b_rdata0 : a_rdata0;
  wire [31:0] s_rd1    = cur ? b_rdata1 : a_rdata1;
  wire        s_we     = cur ? b_mem_we : a_mem_we;
  wire [31:0] s_addr   = cur ? b_mem_addr : a_mem_addr;
  wire [31:0] s_wdata  = cur ? b_mem_wdata : a_mem_wdata;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pops the oldest expected read response.
  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (!reset && (s_rv0 || s_rv1)) begin
      if (s_rv0 && s_rv1) begin
        chk("rvalid_onehot", 65'({s_rv1, s_rv0}), 65'(2'b01));
      end else if (q.size() == 0) begin
        chk("rvalid_unexpected", 65'({s_rv1, s_rv0}), 65'(0));
      end else begin
        e = q.pop_front();
        chk("rdata", 65'({s_rv1, s_rv1 ? s_rd1 : s_rd0}), 65'(e));
      end
    end
  end

  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] eg, input string nm);
    logic        ew;
    logic [31:0] ea, ed;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    ew = 1'b0; ea = '0; ed = '0;
    if (eg[0]) begin ew = r0 & w0; ea = a0; ed = d0; end
    else if (eg[1]) begin ew = r1 & w1; ea = a1; ed = d1; end
    @(negedge clk);
    chk({nm, "_gnt"}, 65'({s_gnt1, s_gnt0}), 65'(eg));
    chk({nm, "_mem"}, {s_we, s_addr, s_wdata}, {ew, ea, ed});
    if (eg != 2'b00) begin
      if (ew) sh[ea[7:0]] = ed;
      else    q.push_back({eg[1], sh[ea[7:0]]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, "idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [0:11];
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = 32'hC0DE_0000 | 32'(i);
      b_mem[i] = 32'hC0DE_0000 | 32'(i);
      sh[i]    = 32'hC0DE_0000 | 32'(i);
    end
    cur = 1'b0;
    do_reset();
    chk("reset_rvalid", 65'({a_rvalid1, a_rvalid0}), 65'(0));

    // Single write is granted in the same cycle.
    step(1, 1, 32'h10, 32'hA5, 0, 0, 0, 0, 2'b01, "wr0");
    chk("wr0_no_rvalid", 65'({s_rv1, s_rv0}), 65'(0));
    idle();

    // Continuous contention with BURST_MAX=4.
    do_reset();
    seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
            2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 12; i++)
      step(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, seq[i], "burst");
    idle();

    // Lone requester keeps the grant well past saturation.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 0, 1, 0, 32'h18, 0, 2'b10, "solo1");
    idle();

    // Round-robin tie-break from IDLE.
    step(1, 0, 32'h1C, 0, 0, 0, 0, 0, 2'b01, "setlast0");
    idle();
    step(1, 0, 32'h1C, 0, 1, 0, 32'h18, 0, 2'b10, "tie_to1");
    idle();
    step(1, 0, 32'h1C, 0, 1, 0, 32'h18, 0, 2'b01, "tie_to0");
    idle();

    // Reset while a port 0 read is in flight drops it.
    step(0, 0, 0, 0, 1, 1, 32'h30, 32'h77, 2'b10, "pre_wr1");
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 2'b01, "rd_before_rst");
    reset = 1'b1;
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_drop_rvalid", 65'({s_rv1, s_rv0}), 65'(0));
    @(posedge clk); #1;
    step(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 2'b01, "tie_after_rst");
    idle();

    // BURST_MAX=1: alternation, and reads see memory as of their acceptance.
    cur = 1'b1;
    do_reset();
    step(0, 0, 0, 0, 1, 0, 32'h20, 0, 2'b10, "b1_rd_first");
    for (int i = 0; i < 6; i++)
      step(1, 1, 32'h20, 32'h55, 1, 0, 32'h20, 0, (i % 2 == 0) ? 2'b01 : 2'b10, "b1_alt");
    idle();
    idle();

    chk("queue_drained", 65'(q.size()), 65'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
